// File: rtl/disco_dma_ctrl_pkg.sv
// Shared definitions for the disk/memory block-transfer controller:
// FSM state encoding, transfer direction codes and default array sizes.
package disco_dma_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned DISK_SIZE_DEF = 500;
    localparam int unsigned MEM_SIZE_DEF  = 1024;

    localparam logic DIR_DISK2MEM = 1'b0;
    localparam logic DIR_MEM2DISK = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/disco_dma_ctrl_if.sv
// Bundle of the CPU request/status signals and the disk/memory access buses.
// slave = controller side, master = CPU and storage side.
interface disco_dma_ctrl_if
    import disco_dma_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              dir;
    logic [ADDR_W-1:0] disk_base;
    logic [ADDR_W-1:0] mem_base;
    logic [ADDR_W-1:0] len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] disk_addr;
    logic              disk_we;
    logic [ADDR_W-1:0] disk_datain;
    logic [ADDR_W-1:0] disk_dataout;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_datain;
    logic [ADDR_W-1:0] mem_dataout;

    modport slave (
        input  start, dir, disk_base, mem_base, len, disk_dataout, mem_dataout,
        output busy, done, err, disk_addr, disk_we, disk_datain,
               mem_addr, mem_we, mem_datain
    );

    modport master (
        output start, dir, disk_base, mem_base, len, disk_dataout, mem_dataout,
        input  busy, done, err, disk_addr, disk_we, disk_datain,
               mem_addr, mem_we, mem_datain
    );

endinterface

// File: rtl/disco_dma_ctrl_range_check.sv
// Combinational overflow test: base+len exceeds SIZE, computed one bit wider
// so a base near the top of the address space cannot wrap into range.
module disco_dma_ctrl_range_check #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SIZE   = 500
) (
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_len,
    output logic              o_over
);

    logic [ADDR_W:0] w_end;

    assign w_end  = {1'b0, i_base} + {1'b0, i_len};
    assign o_over = (w_end > (ADDR_W + 1)'(SIZE));

endmodule

// File: rtl/disco_dma_ctrl.sv
// Block-transfer controller between the disk and data memory. Reads one source
// word per cycle and writes it to the destination one cycle later.
module disco_dma_ctrl
    import disco_dma_ctrl_pkg::*;
#(
    parameter int unsigned DISK_SIZE = DISK_SIZE_DEF,
    parameter int unsigned MEM_SIZE  = MEM_SIZE_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    disco_dma_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    dma_state_e        r_state, w_state_nxt;
    logic              r_dir, w_dir_nxt;
    logic [ADDR_W-1:0] r_disk_base, w_disk_base_nxt, r_mem_base, w_mem_base_nxt;
    logic [ADDR_W-1:0] r_len, w_len_nxt, r_rd_idx, w_rd_idx_nxt, r_wr_idx, w_wr_idx_nxt;
    logic [ADDR_W-1:0] r_disk_addr, w_disk_addr_nxt, r_disk_datain, w_disk_datain_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt, r_mem_datain, w_mem_datain_nxt;
    logic              r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
    logic              r_disk_we, w_disk_we_nxt, r_mem_we, w_mem_we_nxt;
    logic              w_disk_over, w_mem_over;

    disco_dma_ctrl_range_check #(.ADDR_W(ADDR_W), .SIZE(DISK_SIZE)) u_disk_chk (
        .i_base (bus.disk_base),
        .i_len  (bus.len),
        .o_over (w_disk_over)
    );

    disco_dma_ctrl_range_check #(.ADDR_W(ADDR_W), .SIZE(MEM_SIZE)) u_mem_chk (
        .i_base (bus.mem_base),
        .i_len  (bus.len),
        .o_over (w_mem_over)
    );

    // Next-state and next-output decode; outputs are computed for the coming cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_dir_nxt         = r_dir;
        w_disk_base_nxt   = r_disk_base;
        w_mem_base_nxt    = r_mem_base;
        w_len_nxt         = r_len;
        w_rd_idx_nxt      = r_rd_idx;
        w_wr_idx_nxt      = r_wr_idx;
        w_disk_addr_nxt   = r_disk_addr;
        w_disk_datain_nxt = r_disk_datain;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_datain_nxt  = r_mem_datain;
        w_busy_nxt        = r_busy;
        w_err_nxt         = r_err;
        w_done_nxt        = 1'b0;
        w_disk_we_nxt     = 1'b0;
        w_mem_we_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (bus.start) begin
                    w_dir_nxt       = bus.dir;
                    w_disk_base_nxt = bus.disk_base;
                    w_mem_base_nxt  = bus.mem_base;
                    w_len_nxt       = bus.len;
                    w_rd_idx_nxt    = ONE;
                    w_wr_idx_nxt    = ZERO;
                    if (bus.len == ZERO) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                    end else if (w_disk_over || w_mem_over) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else begin
                        // The first source read is issued together with the acceptance.
                        w_state_nxt = ST_XFER;
                        w_busy_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                        if (bus.dir == DIR_DISK2MEM) begin
                            w_disk_addr_nxt = bus.disk_base;
                        end else begin
                            w_mem_addr_nxt = bus.mem_base;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_XFER: begin
                w_busy_nxt   = 1'b1;
                w_wr_idx_nxt = r_wr_idx + ONE;
                if (r_dir == DIR_DISK2MEM) begin
                    w_mem_addr_nxt   = r_mem_base + r_wr_idx;
                    w_mem_datain_nxt = bus.disk_dataout;
                    w_mem_we_nxt     = 1'b1;
                end else begin
                    w_disk_addr_nxt   = r_disk_base + r_wr_idx;
                    w_disk_datain_nxt = bus.mem_dataout;
                    w_disk_we_nxt     = 1'b1;
                end
                if (r_rd_idx < r_len) begin
                    w_rd_idx_nxt = r_rd_idx + ONE;
                    if (r_dir == DIR_DISK2MEM) begin
                        w_disk_addr_nxt = r_disk_base + r_rd_idx;
                    end else begin
                        w_mem_addr_nxt = r_mem_base + r_rd_idx;
                    end
                end else begin
                    // All reads issued; the write just scheduled is the last one.
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_DONE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_dir         <= DIR_DISK2MEM;
            r_disk_base   <= ZERO;
            r_mem_base    <= ZERO;
            r_len         <= ZERO;
            r_rd_idx      <= ZERO;
            r_wr_idx      <= ZERO;
            r_disk_addr   <= ZERO;
            r_disk_datain <= ZERO;
            r_mem_addr    <= ZERO;
            r_mem_datain  <= ZERO;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_disk_we     <= 1'b0;
            r_mem_we      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dir         <= w_dir_nxt;
            r_disk_base   <= w_disk_base_nxt;
            r_mem_base    <= w_mem_base_nxt;
            r_len         <= w_len_nxt;
            r_rd_idx      <= w_rd_idx_nxt;
            r_wr_idx      <= w_wr_idx_nxt;
            r_disk_addr   <= w_disk_addr_nxt;
            r_disk_datain <= w_disk_datain_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_datain  <= w_mem_datain_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_disk_we     <= w_disk_we_nxt;
            r_mem_we      <= w_mem_we_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.disk_addr   = r_disk_addr;
    assign bus.disk_we     = r_disk_we;
    assign bus.disk_datain = r_disk_datain;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_datain  = r_mem_datain;

endmodule

// File: tb/tb_disco_dma_ctrl.sv
// Self-checking bench: directed scenarios plus random transfers checked against
// a word-array model of disk and memory contents and a cycle-count timing model.
module tb_disco_dma_ctrl;
    import disco_dma_ctrl_pkg::*;

    localparam int DSZ = 500;
    localparam int MSZ = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    disco_dma_ctrl_if #(.ADDR_W(32)) bus ();

    disco_dma_ctrl #(.DISK_SIZE(DSZ), .MEM_SIZE(MSZ), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] disk [DSZ];
    logic [31:0] mem [MSZ];
    logic [31:0] exp_disk [DSZ];
    logic [31:0] exp_mem [MSZ];
    bit          filled = 1'b0;
    logic        bd_we = 1'b0;
    logic        bd_sel = 1'b0;
    int          bd_addr = 0;
    logic [31:0] bd_data = 32'h0;

    int n_cmp = 0;
    int n_mis = 0;

    function automatic logic [31:0] init_word(input bit sel, input int i);
        return {(sel ? 16'hBEEF : 16'hD15C), i[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Disk and memory storage: initial fill, backdoor preload and DUT writes.
    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < DSZ; i++) disk[i] <= init_word(1'b0, i);
            for (int i = 0; i < MSZ; i++) mem[i] <= init_word(1'b1, i);
            filled <= 1'b1;
        end else begin
            if (bd_we && !bd_sel) disk[bd_addr] <= bd_data;
            if (bd_we && bd_sel) mem[bd_addr] <= bd_data;
            if (bus.disk_we && bus.disk_addr < DSZ) disk[bus.disk_addr] <= bus.disk_datain;
            if (bus.mem_we && bus.mem_addr < MSZ) mem[bus.mem_addr] <= bus.mem_datain;
        end
    end

    // Storage read ports: data for the address driven this cycle is ready by the next edge.
    always @(negedge clk) begin
        bus.disk_dataout = (bus.disk_addr < DSZ) ? disk[bus.disk_addr] : 32'h0;
        bus.mem_dataout  = (bus.mem_addr < MSZ) ? mem[bus.mem_addr] : 32'h0;
    end

    task automatic bd_write(input logic sel, input int addr, input logic [31:0] data);
        bd_we = 1'b1; bd_sel = sel; bd_addr = addr; bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
        if (sel) exp_mem[addr] = data;
        else exp_disk[addr] = data;
    endtask

    task automatic check_images(input string tag);
        int bd = 0;
        int bm = 0;
        for (int i = 0; i < DSZ; i++) if (disk[i] !== exp_disk[i]) bd++;
        for (int i = 0; i < MSZ; i++) if (mem[i] !== exp_mem[i]) bm++;
        check_val({tag, "_disk_img_bad"}, bd, 0);
        check_val({tag, "_mem_img_bad"}, bm, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_done"}, bus.done, 0);
        check_val({tag, "_err"}, bus.err, 0);
        check_val({tag, "_we"}, {bus.disk_we, bus.mem_we}, 0);
        check_val({tag, "_daddr"}, bus.disk_addr, 0);
        check_val({tag, "_maddr"}, bus.mem_addr, 0);
        check_val({tag, "_ddin"}, bus.disk_datain, 0);
        check_val({tag, "_mdin"}, bus.mem_datain, 0);
    endtask

    // Issues one start at the current negedge and checks the whole transfer.
    task automatic run_xfer(input string tag, input logic d, input logic [31:0] db,
                            input logic [31:0] mb, input logic [31:0] ln, input bit hammer);
        bit bad;
        int exp_dc, exp_wr, done_cyc, we_d, we_m, busy_gap;
        logic exp_err;
        bad = (longint'(db) + longint'(ln) > longint'(DSZ)) ||
              (longint'(mb) + longint'(ln) > longint'(MSZ));
        if (ln == 0) begin
            exp_dc = 1; exp_wr = 0; exp_err = 1'b0;
        end else if (bad) begin
            exp_dc = 1; exp_wr = 0; exp_err = 1'b1;
        end else begin
            exp_dc = int'(ln) + 2; exp_wr = int'(ln); exp_err = 1'b0;
            for (int i = 0; i < int'(ln); i++) begin
                if (d == DIR_DISK2MEM) exp_mem[int'(mb) + i] = exp_disk[int'(db) + i];
                else exp_disk[int'(db) + i] = exp_mem[int'(mb) + i];
            end
        end
        bus.start = 1'b1; bus.dir = d; bus.disk_base = db; bus.mem_base = mb; bus.len = ln;
        done_cyc = 0; we_d = 0; we_m = 0; busy_gap = 0;
        for (int k = 1; k <= 80 && done_cyc == 0; k++) begin
            @(negedge clk);
            if (!hammer) bus.start = 1'b0;
            if (bus.disk_we) we_d++;
            if (bus.mem_we) we_m++;
            if (bus.done) done_cyc = k;
            else if (!bus.busy) busy_gap++;
        end
        bus.start = 1'b0;
        check_val({tag, "_done_cycle"}, done_cyc, exp_dc);
        check_val({tag, "_err"}, bus.err, exp_err);
        check_val({tag, "_busy_at_done"}, bus.busy, 0);
        check_val({tag, "_busy_gap"}, busy_gap, (exp_dc > 1) ? 0 : busy_gap);
        check_val({tag, "_disk_we_cnt"}, we_d, (d == DIR_MEM2DISK) ? exp_wr : 0);
        check_val({tag, "_mem_we_cnt"}, we_m, (d == DIR_DISK2MEM) ? exp_wr : 0);
        @(negedge clk);
        check_val({tag, "_done_single"}, bus.done, 0);
        check_val({tag, "_busy_after"}, bus.busy, 0);
        check_val({tag, "_err_hold"}, bus.err, exp_err);
        check_val({tag, "_we_after"}, {bus.disk_we, bus.mem_we}, 0);
        check_images(tag);
    endtask

    // Reset two write cycles into an 8-word disk-to-memory copy.
    task automatic run_reset_abort();
        int n_done = 0;
        bus.start = 1'b1; bus.dir = DIR_DISK2MEM; bus.disk_base = 32'd20;
        bus.mem_base = 32'd300; bus.len = 32'd8;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) n_done++;
        end
        rst_n = 1'b0;
        exp_mem[300] = exp_disk[20];
        exp_mem[301] = exp_disk[21];
        @(negedge clk);
        check_idle_outputs("rst_abort");
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check_val("rst_abort_no_done", n_done, 0);
        check_images("rst_abort");
    endtask

    initial begin
        logic        d;
        logic [31:0] db, mb, ln;
        int          sel;
        bus.start = 1'b0; bus.dir = 1'b0; bus.disk_base = 32'h0;
        bus.mem_base = 32'h0; bus.len = 32'h0;
        for (int i = 0; i < DSZ; i++) exp_disk[i] = init_word(1'b0, i);
        for (int i = 0; i < MSZ; i++) exp_mem[i] = init_word(1'b1, i);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        bd_write(1'b0, 0, 32'h11); bd_write(1'b0, 1, 32'h22);
        bd_write(1'b0, 2, 32'h33); bd_write(1'b0, 3, 32'h44);
        bd_write(1'b1, 10, 32'hA); bd_write(1'b1, 11, 32'hB); bd_write(1'b1, 12, 32'hC);

        run_xfer("load4", DIR_DISK2MEM, 32'd0, 32'd100, 32'd4, 1'b0);
        check_val("load4_mem103", mem[103], 32'h44);
        run_xfer("save3_edge", DIR_MEM2DISK, 32'd497, 32'd10, 32'd3, 1'b0);
        check_val("save3_disk499", disk[499], 32'hC);
        run_xfer("range_err", DIR_DISK2MEM, 32'd498, 32'd0, 32'd3, 1'b0);
        run_xfer("len_zero", DIR_DISK2MEM, 32'd5, 32'd5, 32'd0, 1'b0);
        run_reset_abort();
        run_xfer("after_rst", DIR_DISK2MEM, 32'd20, 32'd300, 32'd8, 1'b0);
        run_xfer("hammer5", DIR_DISK2MEM, 32'd30, 32'd400, 32'd5, 1'b1);
        run_xfer("back2back", DIR_MEM2DISK, 32'd40, 32'd400, 32'd5, 1'b0);

        for (int t = 0; t < 30; t++) begin
            d   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 5));
            ln  = $urandom_range(1, 12);
            db  = $urandom_range(0, DSZ - 12);
            mb  = $urandom_range(0, MSZ - 12);
            case (sel)
                0: ln = 32'd0;
                3: begin db = DSZ - ln; mb = MSZ - ln; end
                4: begin
                    db = DSZ - ln; mb = MSZ - ln;
                    if ($urandom_range(0, 1) == 0) db = db + 32'd1;
                    else mb = mb + 32'd1;
                end
                5: db = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: ;
            endcase
            run_xfer($sformatf("rnd%0d", t), d, db, mb, ln, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
